// File: rtl/pipe_idexe_stage.sv
// -----------------------------------------------------------------------------
// pipe_idexe_stage
//   ID/EXE pipeline register with a valid/ready handshake. Load-use stalls
//   (e_ready=0) and branch flushes (flush=1) are handled inside the stage. With
//   SKID=1 a second (skid) entry lets the upstream ready be a pure register
//   output. With SKID=0 there is a single entry and d_ready is combinational.
//
// Ports
//   clock, resetn         rising-edge clock, asynchronous active-low reset
//   d_valid / d_ready     ID-side handshake
//   flush                 synchronous kill of every held entry (beats accept)
//   dwreg..djal, daluc,   ID payload: control bits, ALU control, destination
//   drn, dpc4, da, db,    register, PC+4, operands and immediate
//   dimm
//   e_valid / e_ready     EXE-side handshake
//   ewreg..ejal, ealuc,   EXE copy of the payload. ewreg/em2reg/ewmem/ejal
//   ern0, epc4, ea, eb,   are forced to 0 while e_valid=0, and the remaining
//   eimm                  fields hold their last register contents.
//   bubble_cnt            saturating count of edges seen with e_valid=0
// -----------------------------------------------------------------------------
module pipe_idexe_stage #(
   parameter int DATA_W = 32,
   parameter int ALUC_W = 4,
   parameter int RN_W   = 5,
   parameter int SKID   = 1,
   parameter int PERF_W = 16
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              d_valid,
   output logic              d_ready,
   input  logic              flush,
   input  logic              dwreg,
   input  logic              dm2reg,
   input  logic              dwmem,
   input  logic              daluimm,
   input  logic              dshift,
   input  logic              djal,
   input  logic [ALUC_W-1:0] daluc,
   input  logic [RN_W-1:0]   drn,
   input  logic [DATA_W-1:0] dpc4,
   input  logic [DATA_W-1:0] da,
   input  logic [DATA_W-1:0] db,
   input  logic [DATA_W-1:0] dimm,
   output logic              e_valid,
   input  logic              e_ready,
   output logic              ewreg,
   output logic              em2reg,
   output logic              ewmem,
   output logic              ealuimm,
   output logic              eshift,
   output logic              ejal,
   output logic [ALUC_W-1:0] ealuc,
   output logic [RN_W-1:0]   ern0,
   output logic [DATA_W-1:0] epc4,
   output logic [DATA_W-1:0] ea,
   output logic [DATA_W-1:0] eb,
   output logic [DATA_W-1:0] eimm,
   output logic [PERF_W-1:0] bubble_cnt
);

   localparam int PW = 6 + ALUC_W + RN_W + 4 * DATA_W;

   // Saturating increment: sticks at all-ones instead of wrapping to zero.
   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      if (&v) return v;
      return v + {{(PERF_W-1){1'b0}}, 1'b1};
   endfunction

   // ---- stage p0: ID payload as presented by decode ----
   logic [PW-1:0] pay_p0;
   assign pay_p0 = {dwreg, dm2reg, dwmem, daluimm, dshift, djal,
                    daluc, drn, dpc4, da, db, dimm};

   logic          accept;
   logic          consume;
   logic [PW-1:0] main_p1;
   logic          vld_p1;

   assign accept  = d_valid & d_ready;
   assign consume = vld_p1 & e_ready;

   // ---- stage p1: main entry (and optional skid entry) ----
   generate
      if (SKID != 0) begin : g_skid
         logic [PW-1:0] skid_p1;
         logic          skid_vld_p1;

         // skid_vld_p1 is a flop, so d_ready is registered.
         assign d_ready = ~skid_vld_p1;

         always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
               vld_p1      <= 1'b0;
               skid_vld_p1 <= 1'b0;
               main_p1     <= '0;
               skid_p1     <= '0;
            end else if (flush) begin
               vld_p1      <= 1'b0;
               skid_vld_p1 <= 1'b0;
            end else if (!vld_p1 || consume) begin
               // Main frees up this edge. The skid entry is older than
               // anything arriving now, and d_ready=0 while it is full, so
               // the two cases never collide.
               if (skid_vld_p1) begin
                  main_p1     <= skid_p1;
                  vld_p1      <= 1'b1;
                  skid_vld_p1 <= 1'b0;
               end else if (accept) begin
                  main_p1 <= pay_p0;
                  vld_p1  <= 1'b1;
               end else begin
                  vld_p1 <= 1'b0;
               end
            end else if (accept) begin
               // Main is stalled: park the new payload behind it.
               skid_p1     <= pay_p0;
               skid_vld_p1 <= 1'b1;
            end
         end
      end else begin : g_single
         assign d_ready = ~vld_p1 | e_ready;

         always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
               vld_p1  <= 1'b0;
               main_p1 <= '0;
            end else if (flush) begin
               vld_p1 <= 1'b0;
            end else if (!vld_p1 || consume) begin
               if (accept) begin
                  main_p1 <= pay_p0;
                  vld_p1  <= 1'b1;
               end else begin
                  vld_p1 <= 1'b0;
               end
            end
         end
      end
   endgenerate

   // Idle-cycle counter for performance monitoring.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)      bubble_cnt <= '0;
      else if (!vld_p1) bubble_cnt <= sat_inc(bubble_cnt);
   end

   // ---- stage p1 -> EXE: unpack and gate side-effecting controls ----
   logic m_wreg, m_m2reg, m_wmem, m_jal;

   assign {m_wreg, m_m2reg, m_wmem, ealuimm, eshift, m_jal,
           ealuc, ern0, epc4, ea, eb, eimm} = main_p1;

   // A bubble must never write a register or memory, or link on jal.
   assign e_valid = vld_p1;
   assign ewreg   = m_wreg  & vld_p1;
   assign em2reg  = m_m2reg & vld_p1;
   assign ewmem   = m_wmem  & vld_p1;
   assign ejal    = m_jal   & vld_p1;

endmodule

// File: tb/tb_pipe_idexe_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_idexe_stage
//   Directed bench for pipe_idexe_stage. Three instances share one set of
//   inputs: index 0 is SKID=1/PERF_W=16, index 1 is SKID=0, and a third
//   SKID=1 instance has PERF_W=4 for the saturation case. Every phase starts
//   from reset, so each instance is in a known state when it is checked.
// -----------------------------------------------------------------------------
module tb_pipe_idexe_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        d_valid, flush, e_ready;
   logic        dwreg, dm2reg, dwmem, daluimm, dshift, djal;
   logic [3:0]  daluc;
   logic [4:0]  drn;
   logic [31:0] dpc4, da, db, dimm;

   logic        d_ready_v [3];
   logic        e_valid_v [3];
   logic        ewreg_v   [3];
   logic        em2reg_v  [3];
   logic        ewmem_v   [3];
   logic        ealuimm_v [3];
   logic        eshift_v  [3];
   logic        ejal_v    [3];
   logic [3:0]  ealuc_v   [3];
   logic [4:0]  ern0_v    [3];
   logic [31:0] epc4_v    [3];
   logic [31:0] ea_v      [3];
   logic [31:0] eb_v      [3];
   logic [31:0] eimm_v    [3];
   logic [15:0] bc16_v    [2];
   logic [3:0]  bc4;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_idexe_stage #(.SKID(1), .PERF_W(16)) u_s1 (
      .clock(clk), .resetn(resetn), .d_valid(d_valid), .d_ready(d_ready_v[0]),
      .flush(flush), .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem),
      .daluimm(daluimm), .dshift(dshift), .djal(djal), .daluc(daluc),
      .drn(drn), .dpc4(dpc4), .da(da), .db(db), .dimm(dimm),
      .e_valid(e_valid_v[0]), .e_ready(e_ready), .ewreg(ewreg_v[0]),
      .em2reg(em2reg_v[0]), .ewmem(ewmem_v[0]), .ealuimm(ealuimm_v[0]),
      .eshift(eshift_v[0]), .ejal(ejal_v[0]), .ealuc(ealuc_v[0]),
      .ern0(ern0_v[0]), .epc4(epc4_v[0]), .ea(ea_v[0]), .eb(eb_v[0]),
      .eimm(eimm_v[0]), .bubble_cnt(bc16_v[0]));

   pipe_idexe_stage #(.SKID(0), .PERF_W(16)) u_s0 (
      .clock(clk), .resetn(resetn), .d_valid(d_valid), .d_ready(d_ready_v[1]),
      .flush(flush), .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem),
      .daluimm(daluimm), .dshift(dshift), .djal(djal), .daluc(daluc),
      .drn(drn), .dpc4(dpc4), .da(da), .db(db), .dimm(dimm),
      .e_valid(e_valid_v[1]), .e_ready(e_ready), .ewreg(ewreg_v[1]),
      .em2reg(em2reg_v[1]), .ewmem(ewmem_v[1]), .ealuimm(ealuimm_v[1]),
      .eshift(eshift_v[1]), .ejal(ejal_v[1]), .ealuc(ealuc_v[1]),
      .ern0(ern0_v[1]), .epc4(epc4_v[1]), .ea(ea_v[1]), .eb(eb_v[1]),
      .eimm(eimm_v[1]), .bubble_cnt(bc16_v[1]));

   pipe_idexe_stage #(.SKID(1), .PERF_W(4)) u_p4 (
      .clock(clk), .resetn(resetn), .d_valid(d_valid), .d_ready(d_ready_v[2]),
      .flush(flush), .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem),
      .daluimm(daluimm), .dshift(dshift), .djal(djal), .daluc(daluc),
      .drn(drn), .dpc4(dpc4), .da(da), .db(db), .dimm(dimm),
      .e_valid(e_valid_v[2]), .e_ready(e_ready), .ewreg(ewreg_v[2]),
      .em2reg(em2reg_v[2]), .ewmem(ewmem_v[2]), .ealuimm(ealuimm_v[2]),
      .eshift(eshift_v[2]), .ejal(ejal_v[2]), .ealuc(ealuc_v[2]),
      .ern0(ern0_v[2]), .epc4(epc4_v[2]), .ea(ea_v[2]), .eb(eb_v[2]),
      .eimm(eimm_v[2]), .bubble_cnt(bc4));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      d_valid = 0; flush = 0; e_ready = 0;
      dwreg = 0; dm2reg = 0; dwmem = 0; daluimm = 0; dshift = 0; djal = 0;
      daluc = 0; drn = 0; dpc4 = 0; da = 0; db = 0; dimm = 0;
   endtask

   // Reset held for three edges, released 1 time unit after the third.
   task automatic do_reset();
      resetn = 0;
      clr_inputs();
      repeat (3) tick();
      resetn = 1;
   endtask

   initial begin
      logic [31:0] seq [4];
      seq[0] = 32'h11111111; seq[1] = 32'h22222222;
      seq[2] = 32'h33333333; seq[3] = 32'h44444444;

      // Reset state and streaming at full rate.
      do_reset();
      chk("rst_evalid", e_valid_v[0], 0);
      chk("rst_ea",     ea_v[0], 0);
      chk("rst_ern0",   ern0_v[0], 0);
      chk("rst_bubble", bc16_v[0], 0);
      chk("rst_dready", d_ready_v[0], 1);
      d_valid = 1; e_ready = 1; drn = 5'd7; daluc = 4'hA; dpc4 = 32'h104;
      for (int i = 0; i < 4; i++) begin
         da = seq[i];
         tick();
         chk("stream_evalid", e_valid_v[0], 1);
         chk("stream_ea",     ea_v[0], seq[i]);
         chk("stream_dready", d_ready_v[0], 1);
      end
      chk("stream_ern0",   ern0_v[0], 7);
      chk("stream_ealuc",  ealuc_v[0], 4'hA);
      chk("stream_epc4",   epc4_v[0], 32'h104);
      chk("stream_bubble", bc16_v[0], 1);

      // Stall with the skid entry filling and draining in order.
      do_reset();
      d_valid = 1; e_ready = 0; da = 32'hA;
      tick();
      chk("stall_ea_a",    ea_v[0], 32'hA);
      chk("stall_dready0", d_ready_v[0], 1);
      da = 32'hB;
      tick();
      chk("stall_hold_a",  ea_v[0], 32'hA);
      chk("stall_dready1", d_ready_v[0], 0);
      d_valid = 0;
      tick();
      chk("stall_hold_a2", ea_v[0], 32'hA);
      chk("stall_evalid",  e_valid_v[0], 1);
      e_ready = 1;
      tick();
      chk("drain_ea_b",    ea_v[0], 32'hB);
      chk("drain_evalid",  e_valid_v[0], 1);
      chk("drain_dready",  d_ready_v[0], 1);
      tick();
      chk("drain_empty",   e_valid_v[0], 0);

      // Flush beats accept and clears both entries.
      do_reset();
      d_valid = 1; e_ready = 0; dwreg = 1; dwmem = 1; da = 32'h1;
      tick();
      chk("fl_ewreg_pre", ewreg_v[0], 1);
      da = 32'h2;
      tick();
      chk("fl_skidfull", d_ready_v[0], 0);
      flush = 1; da = 32'hDEAD;
      tick();
      chk("fl_evalid", e_valid_v[0], 0);
      chk("fl_ewreg",  ewreg_v[0], 0);
      chk("fl_ewmem",  ewmem_v[0], 0);
      chk("fl_ea",     ea_v[0], 32'h1);
      chk("fl_dready", d_ready_v[0], 1);
      // Ready is high now, but flush still drops the incoming payload.
      tick();
      chk("fl2_evalid", e_valid_v[0], 0);
      chk("fl2_ea",     ea_v[0], 32'h1);
      flush = 0; d_valid = 0;
      tick();
      chk("fl3_evalid", e_valid_v[0], 0);

      // Bubble gating of the side-effecting controls.
      do_reset();
      d_valid = 1; e_ready = 1; dwreg = 1; dwmem = 1; dm2reg = 1; djal = 1;
      daluimm = 1; da = 32'h55;
      tick();
      chk("bg_ewreg_on", ewreg_v[0], 1);
      chk("bg_ejal_on",  ejal_v[0], 1);
      chk("bg_cnt1",     bc16_v[0], 1);
      d_valid = 0;
      tick();
      chk("bg_evalid",  e_valid_v[0], 0);
      chk("bg_ewreg",   ewreg_v[0], 0);
      chk("bg_ewmem",   ewmem_v[0], 0);
      chk("bg_em2reg",  em2reg_v[0], 0);
      chk("bg_ejal",    ejal_v[0], 0);
      chk("bg_ea_hold", ea_v[0], 32'h55);
      chk("bg_aluimm",  ealuimm_v[0], 1);
      chk("bg_cnt1b",   bc16_v[0], 1);
      tick();
      chk("bg_cnt2",    bc16_v[0], 2);
      tick();
      chk("bg_cnt3",    bc16_v[0], 3);

      // Single-entry build: combinational ready, no gap on back-to-back.
      do_reset();
      d_valid = 1; e_ready = 0; da = 32'h100;
      #1;
      chk("s0_dready_empty", d_ready_v[1], 1);
      tick();
      chk("s0_evalid",       e_valid_v[1], 1);
      chk("s0_ea1",          ea_v[1], 32'h100);
      chk("s0_dready_stall", d_ready_v[1], 0);
      e_ready = 1; da = 32'h200;
      #1;
      chk("s0_dready_comb",  d_ready_v[1], 1);
      tick();
      chk("s0_ea2",          ea_v[1], 32'h200);
      chk("s0_evalid2",      e_valid_v[1], 1);
      da = 32'h300;
      tick();
      chk("s0_ea3",          ea_v[1], 32'h300);
      flush = 1;
      tick();
      chk("s0_flush_evalid", e_valid_v[1], 0);
      chk("s0_flush_ea",     ea_v[1], 32'h300);
      flush = 0; d_valid = 0;

      // Asynchronous reset mid-transfer, then counter saturation.
      do_reset();
      d_valid = 1; e_ready = 0; da = 32'h77;
      tick();
      chk("mid_evalid_pre", e_valid_v[0], 1);
      #2 resetn = 0;
      #1;
      chk("mid_evalid", e_valid_v[0], 0);
      chk("mid_ea",     ea_v[0], 0);
      chk("mid_dready", d_ready_v[0], 1);
      do_reset();
      repeat (20) tick();
      chk("sat_cnt4",  bc4, 15);
      chk("sat_cnt16", bc16_v[0], 20);
      repeat (3) tick();
      chk("sat_hold",  bc4, 15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Safety net in case the main sequence stalls.
   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
